// File: rtl/truth_sweep_ctrl.sv
// truth_sweep_ctrl: walks every input combination of an N_IN-input
// combinational function and captures its output into a truth table.
// It also counts how many vectors produced a 1.
// Optional feature: define SWEEP_GRAY_EN to step drv_out in Gray order.
// The table is still indexed by the binary value of drv_out, so the
// captured contents match binary mode.
module truth_sweep_ctrl #(
  parameter int N_IN   = 6,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   y_in,
  output logic [N_IN-1:0]        drv_out,
  output logic                   busy,
  output logic                   done,
  output logic [N_IN:0]          ones_cnt,
  output logic [(1<<N_IN)-1:0]   truth_tbl
);

  localparam int              NV       = 1 << N_IN;
  localparam logic [3:0]      SETTLE_C = 4'(SETTLE);
  localparam logic [N_IN-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [N_IN-1:0]   drv_out_q, drv_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [N_IN:0]     ones_cnt_q, ones_cnt_d;
  logic [NV-1:0]     truth_tbl_q, truth_tbl_d;

  // Map a sweep position to the vector driven onto the function inputs
  function automatic logic [N_IN-1:0] code(input logic [N_IN-1:0] i);
`ifdef SWEEP_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  // Next-state and next-output logic for the sweep sequencer
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wait_cnt_d  = wait_cnt_q;
    drv_out_d   = drv_out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ones_cnt_d  = ones_cnt_q;
    truth_tbl_d = truth_tbl_q;
    case (state_q)
      S_IDLE: begin
        // abort has priority over a simultaneous start
        if (start && !abort) begin
          state_d     = S_SWEEP;
          truth_tbl_d = '0;
          ones_cnt_d  = '0;
          idx_d       = '0;
          wait_cnt_d  = '0;
          drv_out_d   = code('0);
          busy_d      = 1'b1;
        end
      end
      S_SWEEP: begin
        if (abort) begin
          // partial table and count are deliberately kept
          state_d    = S_IDLE;
          drv_out_d  = '0;
          wait_cnt_d = '0;
          busy_d     = 1'b0;
        end else if (wait_cnt_q != SETTLE_C) begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end else begin
          truth_tbl_d[drv_out_q] = y_in;
          ones_cnt_d             = ones_cnt_q + {{N_IN{1'b0}}, y_in};
          wait_cnt_d             = '0;
          if (idx_q == IDX_LAST) begin
            state_d   = S_DONE;
            drv_out_d = '0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else begin
            idx_d     = idx_q + 1'b1;
            drv_out_d = code(idx_q + 1'b1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        drv_out_d = '0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State and registered outputs, cleared asynchronously by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      wait_cnt_q  <= '0;
      drv_out_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ones_cnt_q  <= '0;
      truth_tbl_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_cnt_q  <= wait_cnt_d;
      drv_out_q   <= drv_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ones_cnt_q  <= ones_cnt_d;
      truth_tbl_q <= truth_tbl_d;
    end
  end

  assign drv_out   = drv_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ones_cnt  = ones_cnt_q;
  assign truth_tbl = truth_tbl_q;

endmodule

// File: tb/tb_truth_sweep_ctrl.sv
// Testbench for truth_sweep_ctrl (N_IN=6, SETTLE=1).
// The function under control is a lookup table chosen per sweep.
// The reference model predicts drv_out per cycle, the final table, the
// popcount and the done timing directly from the sweep rules.
// Build with SWEEP_GRAY_EN defined to exercise Gray order.
module tb_truth_sweep_ctrl;

  localparam int N_IN  = 6;
  localparam int SETTLE = 1;
  localparam int NV    = 1 << N_IN;
  localparam int HOLD  = SETTLE + 1;
  localparam int SWEEP_CYC = NV * HOLD;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            y_in;
  logic [N_IN-1:0] drv_out;
  logic            busy;
  logic            done;
  logic [N_IN:0]   ones_cnt;
  logic [NV-1:0]   truth_tbl;

  logic [NV-1:0]   func_tbl = '0;

  int checks = 0;
  int errors = 0;

  assign y_in = func_tbl[drv_out];

  always #5 clk = ~clk;

  truth_sweep_ctrl #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .y_in     (y_in),
    .drv_out  (drv_out),
    .busy     (busy),
    .done     (done),
    .ones_cnt (ones_cnt),
    .truth_tbl(truth_tbl)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Vector expected at sweep position i
  function automatic logic [N_IN-1:0] code_of(input int i);
    logic [N_IN-1:0] b;
    b = N_IN'(i);
`ifdef SWEEP_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  task automatic check_idle_zero(input string tag);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_done"}, 64'(done), 64'd0);
    check_val({tag, "_drv"}, 64'(drv_out), 64'd0);
    check_val({tag, "_ones"}, 64'(ones_cnt), 64'd0);
    check_val({tag, "_tbl"}, 64'(truth_tbl), 64'd0);
  endtask

  // Full sweep against the model; optionally pokes start mid-sweep
  task automatic run_sweep(input string tag, input bit poke_start);
    int cyc;
    int bad_drv;
    int bad_busy;
    int bad_step;
    int exp_ones;
    logic [N_IN-1:0] prev;
    exp_ones = 0;
    for (int i = 0; i < NV; i++) exp_ones += int'(func_tbl[i]);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    cyc = 0; bad_drv = 0; bad_busy = 0; bad_step = 0; prev = '0;
    while (!done && cyc < SWEEP_CYC + 20) begin
      if (cyc < SWEEP_CYC) begin
        if (drv_out !== code_of(cyc / HOLD)) bad_drv++;
        if (busy !== 1'b1) bad_busy++;
`ifdef SWEEP_GRAY_EN
        if (cyc > 0 && (cyc % HOLD) == 0 && $countones(drv_out ^ prev) != 1) bad_step++;
`endif
      end
      prev = drv_out;
      start = (poke_start && cyc == 37);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check_val({tag, "_cycles"}, 64'(cyc), 64'(SWEEP_CYC));
    check_val({tag, "_drv_seq"}, 64'(bad_drv), 64'd0);
    check_val({tag, "_busy_run"}, 64'(bad_busy), 64'd0);
    check_val({tag, "_gray_step"}, 64'(bad_step), 64'd0);
    check_val({tag, "_done"}, 64'(done), 64'd1);
    check_val({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check_val({tag, "_drv_at_done"}, 64'(drv_out), 64'd0);
    check_val({tag, "_tbl"}, 64'(truth_tbl), 64'(func_tbl));
    check_val({tag, "_ones"}, 64'(ones_cnt), 64'(exp_ones));
    @(negedge clk);
    check_val({tag, "_done_pulse"}, 64'(done), 64'd0);
    check_val({tag, "_tbl_hold"}, 64'(truth_tbl), 64'(func_tbl));
  endtask

  initial begin
    logic [NV-1:0] exp_tbl;
    int exp_ones;
    int done_seen;

    #1;
    check_idle_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // AND-of-all-inputs stub: only the top entry is 1
    for (int i = 0; i < NV; i++) func_tbl[i] = (i == NV - 1);
    check_val("and_stub_model", 64'(func_tbl), 64'h8000_0000_0000_0000);
    run_sweep("and_stub", 1'b0);
    check_val("and_stub_ones_const", 64'(ones_cnt), 64'd1);

    // Input-A stub
    for (int i = 0; i < NV; i++) func_tbl[i] = i[0];
    run_sweep("a_stub", 1'b0);
    check_val("a_stub_tbl_const", 64'(truth_tbl), 64'hAAAA_AAAA_AAAA_AAAA);

    // Boundary tables: all zeros and all ones (ones_cnt reaches 64)
    func_tbl = '0;
    run_sweep("all0", 1'b0);
    func_tbl = '1;
    run_sweep("all1", 1'b0);

    // Random functions, one with a mid-sweep start pulse
    for (int r = 0; r < 4; r++) begin
      func_tbl = {$urandom, $urandom};
      run_sweep($sformatf("rand%0d", r), r == 1);
    end

    // Abort at cycle 20 of a sweep
    func_tbl = {$urandom, $urandom};
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk) abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    exp_tbl = '0;
    exp_ones = 0;
    for (int j = 0; j < 20 / HOLD; j++) begin
      exp_tbl[code_of(j)] = func_tbl[code_of(j)];
      exp_ones += int'(func_tbl[code_of(j)]);
    end
    check_val("abort_busy", 64'(busy), 64'd0);
    check_val("abort_done", 64'(done), 64'd0);
    check_val("abort_drv", 64'(drv_out), 64'd0);
    check_val("abort_tbl_partial", 64'(truth_tbl), 64'(exp_tbl));
    check_val("abort_ones_partial", 64'(ones_cnt), 64'(exp_ones));
    done_seen = 0;
    repeat (SWEEP_CYC + 10) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check_val("abort_no_done", 64'(done_seen), 64'd0);
    check_val("abort_tbl_kept", 64'(truth_tbl), 64'(exp_tbl));

    // Full sweep after abort
    run_sweep("after_abort", 1'b0);

    // Asynchronous reset mid-sweep
    func_tbl = '1;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (30) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_idle_zero("async_rst");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    done_seen = 0;
    repeat (SWEEP_CYC + 10) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check_val("rst_no_done", 64'(done_seen), 64'd0);
    check_idle_zero("after_rst");

    // start and abort together in IDLE: stays idle
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(posedge clk);
    #1;
    check_val("start_abort_busy", 64'(busy), 64'd0);
    check_val("start_abort_drv", 64'(drv_out), 64'd0);
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    @(posedge clk);
    #1;
    check_val("start_abort_busy2", 64'(busy), 64'd0);

    // Recovery sweep
    func_tbl = {$urandom, $urandom};
    run_sweep("final", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_sweep_ctrl.md
# truth_sweep_ctrl

Sequencer that drives every input combination of an N-input combinational logic function, such as the team's 6-input/1-output `example` cone. It captures the function's output into a truth-table register and counts the ones. It sits beside the combinational block under test in self-checking benches and on-chip BIST wrappers, and replaces hand-written stimulus sequences with a start/done handshake.

## Interface

- `N_IN`, default 6: number of function inputs; legal range 1–8.
- `SETTLE`, default 1: extra cycles each vector is held before sampling; legal range 0–15.

Ports:

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a sweep; accepted only in IDLE.
- `abort`  in  1  cancel a sweep in progress.
- `y_in`  in  1  output of the function under control.
- `drv_out`  out  N_IN  vector driven onto the function inputs (bit 0 = first input, A).
- `busy`  out  1  high while a sweep is running.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `ones_cnt`  out  N_IN+1  number of vectors for which `y_in` was 1.
- `truth_tbl`  out  2**N_IN  bit i = `y_in` sampled when `drv_out` == i.

## Operation

- States:
  - IDLE: `drv_out`=0, `busy`=0.
  - SWEEP: `busy`=1.
  - DONE: `done`=1 for one cycle, then always IDLE.
- Internal counters:
  - `idx`: N_IN bits, sweep position.
  - `wait_cnt`: 4 bits.
- IDLE → SWEEP on `start`=1 and `abort`=0:
  - clear `truth_tbl` and `ones_cnt`;
  - `idx`←0, `wait_cnt`←0, `drv_out`←code(0).
- SWEEP, when `wait_cnt` ≠ SETTLE: `wait_cnt`++ and `drv_out` holds.
- SWEEP, when `wait_cnt` == SETTLE:
  - `truth_tbl[drv_out]`←`y_in` and `ones_cnt` += `y_in`;
  - if `idx` == 2**N_IN−1, go to DONE with `drv_out`←0;
  - otherwise `idx`++, `drv_out`←code(`idx`+1), `wait_cnt`←0.
- code(i) = i (binary order). See Configuration for the alternative.
- `abort`=1 in SWEEP → IDLE next edge:
  - no `done` pulse;
  - `truth_tbl` and `ones_cnt` keep their partial contents.
- `start` in SWEEP or DONE is ignored and not queued. `abort` in IDLE or DONE is ignored.
- `start` and `abort` asserted together in IDLE: abort wins, the block stays in IDLE.
- `ones_cnt` never wraps: the maximum is 2**N_IN, which fits in N_IN+1 bits.

## Timing

- Reset values: state IDLE; `drv_out`, `busy`, `done`, `ones_cnt`, `truth_tbl`, `idx`, `wait_cnt` all 0.
- `rst_n` low mid-sweep clears everything immediately (asynchronously), with no `done` pulse.
- Each vector is held for SETTLE+1 cycles. `y_in` is sampled on the last edge of that window, so the combinational path gets SETTLE+1 cycles to settle.
- `start` sampled at edge k:
  - `busy` rises after edge k;
  - the final sample is at edge k + 2**N_IN·(SETTLE+1);
  - `done` is high for the following cycle;
  - `busy` falls in the same cycle that `done` rises.
- Defaults (N_IN=6, SETTLE=1): 128 cycles in SWEEP, `done` after edge k+128.
- `truth_tbl` and `ones_cnt` are final and stable when `done`=1, and hold until the next accepted `start`.
- Back-to-back sweeps: `start` must be asserted in IDLE, i.e. at the earliest on the edge after `done`.

## Configuration

- `SWEEP_GRAY_EN` defined:
  - code(i) = i ^ (i >> 1) (Gray order), so consecutive vectors differ in exactly one input bit, giving hazard-free stepping;
  - `truth_tbl` is still indexed by the binary value of `drv_out`, so the table contents are identical to binary mode.
- `SWEEP_GRAY_EN` undefined: code(i) = i, and no Gray logic is instantiated.

## Test plan

- Stub `y_in` = &`drv_out`, defaults, `start` pulse → `done` after exactly 128 cycles; `ones_cnt`=1; `truth_tbl`=64'h8000_0000_0000_0000.
- Stub `y_in` = `drv_out[0]`, SETTLE=0 → `done` after 64 cycles; `ones_cnt`=32; `truth_tbl`=64'hAAAA_AAAA_AAAA_AAAA.
- Reference function `example` connected (A..F = `drv_out[0..5]`) → `truth_tbl` bits 9 (A=1,D=1), 12 (C=1,D=1), 8 (D=1) and 40 (D=1,F=1) equal the function's outputs at those input values.
- `abort` at cycle 20 of a sweep → IDLE next edge, no `done`, `drv_out`=0. A second `start` gives a full, correct result. `start` pulsed mid-sweep has no effect.
- `rst_n` driven low for 3 cycles mid-sweep → all outputs 0 immediately. `start` together with `abort` in IDLE → remains IDLE.
- With `SWEEP_GRAY_EN` → `drv_out` sequence 0,1,3,2,6,7,5,4…; every step has Hamming distance 1; `truth_tbl` matches the binary-mode run bit-for-bit.
